ar_router: RTL and testbench
============================

AR_ROUTER -- requirements
Module: ar_router

Interface
REQ-001 Parameter NUM_M, default 2, meaning number of master ports.
REQ-002 Parameter NUM_S, default 2, meaning number of slave ports.
REQ-003 Parameter ID_W, default 4, meaning master ARID width; slave ARID width SID_W = ID_W + 4, with the upper 4 bits carrying the master index.
REQ-004 Parameter ADDR_W, default 32, meaning address width.
REQ-005 Parameter SEL_LSB, default 16, meaning lowest address bit of the slave-select field; the field width is SEL_W = max(1, clog2(NUM_S)).
REQ-006 Port ACLK, input, 1, meaning the single clock; the block is one clock; reset is asynchronous and active-low.
REQ-007 Port ARESETn, input, 1, meaning asynchronous active-low reset.
REQ-008 Ports ARID_M / ARADDR_M / ARLEN_M / ARSIZE_M / ARBURST_M, inputs, NUM_M x (ID_W / ADDR_W / 4 / 3 / 2), meaning packed master request payloads.
REQ-009 Port ARVALID_M, input, NUM_M, meaning master request valid; port ARREADY_M, output, NUM_M, meaning master request accepted.
REQ-010 Ports ARID_S / ARADDR_S / ARLEN_S / ARSIZE_S / ARBURST_S, outputs, NUM_S x (SID_W / ADDR_W / 4 / 3 / 2), meaning packed slave payloads.
REQ-011 Port ARVALID_S, output, NUM_S, meaning slave request valid; port ARREADY_S, input, NUM_S, meaning slave accepted.
REQ-012 Port DECERR_VALID, output, 1; DECERR_ID, output, SID_W; DECERR_LEN, output, 4; DECERR_READY, input, 1; meaning decode-error hand-off to the read-data channel.

Function
REQ-013 The block SHALL run an FSM with states IDLE, SEND, and ERR.
REQ-014 In IDLE, if any ARVALID_M bit is set, the block SHALL pick one master by round-robin starting after the last-granted index (reset pointer: master 0 has highest priority), pulse that master's ARREADY_M for exactly one cycle, and latch its payload.
REQ-015 Decode: the slave index SHALL be ADDR[SEL_LSB +: SEL_W]. A hit requires the index < NUM_S and all address bits above SEL_LSB+SEL_W to be zero; anything else is a miss.
REQ-016 On a hit, the block SHALL go to SEND. On a miss, it SHALL go to ERR (only when AR_DECERR_EN is defined; see REQ-026).
REQ-017 In SEND, ARVALID_S[sel] SHALL be 1 and the payload SHALL be driven from the latch, held stable until ARREADY_S[sel]; all other ARVALID_S bits SHALL be 0.
REQ-018 Latency from master accept to slave ARVALID SHALL be 1 cycle. At most one request SHALL be in flight.
REQ-019 ARID_S SHALL equal {master index (4 bits), ARID_M}.
REQ-020 On the ARVALID_S && ARREADY_S cycle, the block SHALL return to IDLE and advance the round-robin pointer past the granted master. A new grant is possible on the next cycle, giving a minimum of 2 cycles per request.
REQ-021 In ERR, DECERR_VALID SHALL be 1 with the latched ID and LEN; on DECERR_READY the block SHALL return to IDLE and advance the pointer.
REQ-022 ARREADY_M SHALL never be asserted outside IDLE.
REQ-023 Inactive slave payload outputs SHALL be driven to zero.
REQ-024 A master dropping ARVALID_M before it is granted SHALL be ignored without error.

Reset
REQ-025 While ARESETn is low, the block SHALL be in IDLE; all ARREADY_M, ARVALID_S, and DECERR_VALID SHALL be 0; latched payloads SHALL be 0; the pointer SHALL be 0. A reset mid-SEND or mid-ERR SHALL abandon the request immediately.

Configuration
REQ-026 Macro AR_DECERR_EN: when defined, misses follow REQ-021. When undefined, misses SHALL be routed to slave NUM_S-1 via SEND, the DECERR outputs SHALL be tied to 0, and the ERR state SHALL be absent.

Verification
REQ-027 M0 reads 0x0000_0100, S0 ARREADY is held 0 for 3 cycles -> ARREADY_M[0] pulses once; ARVALID_S[0] is high 1 cycle later with ID 0x0_x and payload stable until ARREADY.
REQ-028 M0 and M1 both valid continuously, with slaves always ready -> grants alternate M0, M1, M0, M1, with one accept every 2 cycles.
REQ-029 M1 reads 0x0001_0040 with ARID=0x5 -> ARVALID_S[1]=1 with ARID_S=0x15.
REQ-030 With AR_DECERR_EN, M0 reads 0x0004_0000 with LEN=3 -> DECERR_VALID=1, DECERR_ID=0x0_x, DECERR_LEN=3, and no ARVALID_S; without the macro, the request goes to S1.
REQ-031 ARESETn is asserted during SEND -> ARVALID_S drops to 0 asynchronously; after release, the first grant goes to M0.

Source files
------------

// File: rtl/ar_router.sv
// AR channel router: round-robin master grant, address decode, one request in flight (optional AR_DECERR_EN adds ERR state).
// Latency: master accept to slave ARVALID is 1 cycle; minimum 2 cycles per request.
// Backpressure: latched payload held until ARREADY_S / DECERR_READY; masters see ARREADY_M only in IDLE.
module ar_router #(
   parameter int NUM_M   = 2,
   parameter int NUM_S   = 2,
   parameter int ID_W    = 4,
   parameter int ADDR_W  = 32,
   parameter int SEL_LSB = 16
) (
   input  logic                      ACLK,
   input  logic                      ARESETn,
   input  logic [NUM_M*ID_W-1:0]     ARID_M,
   input  logic [NUM_M*ADDR_W-1:0]   ARADDR_M,
   input  logic [NUM_M*4-1:0]        ARLEN_M,
   input  logic [NUM_M*3-1:0]        ARSIZE_M,
   input  logic [NUM_M*2-1:0]        ARBURST_M,
   input  logic [NUM_M-1:0]          ARVALID_M,
   output logic [NUM_M-1:0]          ARREADY_M,
   output logic [NUM_S*(ID_W+4)-1:0] ARID_S,
   output logic [NUM_S*ADDR_W-1:0]   ARADDR_S,
   output logic [NUM_S*4-1:0]        ARLEN_S,
   output logic [NUM_S*3-1:0]        ARSIZE_S,
   output logic [NUM_S*2-1:0]        ARBURST_S,
   output logic [NUM_S-1:0]          ARVALID_S,
   input  logic [NUM_S-1:0]          ARREADY_S,
   output logic                      DECERR_VALID,
   output logic [ID_W+3:0]           DECERR_ID,
   output logic [3:0]                DECERR_LEN,
   input  logic                      DECERR_READY
);

   localparam int SID_W  = ID_W + 4;
   localparam int SEL_W  = (NUM_S > 1) ? $clog2(NUM_S) : 1;
   localparam int PTR_W  = (NUM_M > 1) ? $clog2(NUM_M) : 1;
   localparam int HI_LSB = SEL_LSB + SEL_W;

`ifdef AR_DECERR_EN
   typedef enum logic [1:0] {IDLE, SEND, ERR} state_t;
`else
   typedef enum logic {IDLE, SEND} state_t;
`endif

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, gnt_idx, lat_mst;
   logic               gnt_vld, gnt_hit, done;
   logic [ID_W-1:0]    g_id, lat_id;
   logic [ADDR_W-1:0]  g_addr, lat_addr;
   logic [3:0]         g_len, lat_len;
   logic [2:0]         g_size, lat_size;
   logic [1:0]         g_burst, lat_burst;
   logic [SEL_W-1:0]   gnt_sel, lat_sel;

   // Rotated priority scan; lowest rotation offset wins, so it is written last.
   always_comb begin
      int rot;
      rot     = 0;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int i = NUM_M - 1; i >= 0; i--) begin
         rot = int'(ptr_q) + i;
         if (rot >= NUM_M) rot = rot - NUM_M;
         if (ARVALID_M[PTR_W'(rot)]) begin
            gnt_vld = 1'b1;
            gnt_idx = PTR_W'(rot);
         end
      end
   end

   always_comb begin
      g_id = '0; g_addr = '0; g_len = '0; g_size = '0; g_burst = '0;
      for (int m = 0; m < NUM_M; m++) begin
         if (gnt_idx == PTR_W'(m)) begin
            g_id    = ARID_M[m*ID_W +: ID_W];
            g_addr  = ARADDR_M[m*ADDR_W +: ADDR_W];
            g_len   = ARLEN_M[m*4 +: 4];
            g_size  = ARSIZE_M[m*3 +: 3];
            g_burst = ARBURST_M[m*2 +: 2];
         end
      end
      gnt_sel = g_addr[SEL_LSB +: SEL_W];
      gnt_hit = ((g_addr >> HI_LSB) == '0) && (32'(gnt_sel) < NUM_S);
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (gnt_vld) begin
`ifdef AR_DECERR_EN
               state_d = gnt_hit ? SEND : ERR;
`else
               state_d = SEND;
`endif
            end
         end
         SEND: begin
            if (ARREADY_S[lat_sel]) begin
               state_d = IDLE;
               done    = 1'b1;
            end
         end
`ifdef AR_DECERR_EN
         ERR: begin
            if (DECERR_READY) begin
               state_d = IDLE;
               done    = 1'b1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // Without decode errors, misses fall through to the last slave.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         ptr_q     <= '0;
         lat_mst   <= '0;
         lat_id    <= '0;
         lat_addr  <= '0;
         lat_len   <= '0;
         lat_size  <= '0;
         lat_burst <= '0;
         lat_sel   <= '0;
      end else begin
         if (state_q == IDLE && gnt_vld) begin
            lat_mst   <= gnt_idx;
            lat_id    <= g_id;
            lat_addr  <= g_addr;
            lat_len   <= g_len;
            lat_size  <= g_size;
            lat_burst <= g_burst;
            lat_sel   <= gnt_hit ? gnt_sel : SEL_W'(NUM_S - 1);
         end
         if (done) ptr_q <= (lat_mst == PTR_W'(NUM_M - 1)) ? '0 : lat_mst + 1'b1;
      end
   end

   // Reset gates the grant so a master held valid through reset is never acked.
   always_comb begin
      ARREADY_M = '0;
      if (ARESETn && state_q == IDLE && gnt_vld) ARREADY_M[gnt_idx] = 1'b1;
   end

   always_comb begin
      ARVALID_S = '0;
      ARID_S    = '0;
      ARADDR_S  = '0;
      ARLEN_S   = '0;
      ARSIZE_S  = '0;
      ARBURST_S = '0;
      if (state_q == SEND) begin
         ARVALID_S[lat_sel]                = 1'b1;
         ARID_S[lat_sel*SID_W +: SID_W]    = {4'(lat_mst), lat_id};
         ARADDR_S[lat_sel*ADDR_W +: ADDR_W] = lat_addr;
         ARLEN_S[lat_sel*4 +: 4]           = lat_len;
         ARSIZE_S[lat_sel*3 +: 3]          = lat_size;
         ARBURST_S[lat_sel*2 +: 2]         = lat_burst;
      end
   end

`ifdef AR_DECERR_EN
   assign DECERR_VALID = (state_q == ERR);
   assign DECERR_ID    = (state_q == ERR) ? {4'(lat_mst), lat_id} : '0;
   assign DECERR_LEN   = (state_q == ERR) ? lat_len : '0;
`else
   logic unused_decerr_ready;
   assign unused_decerr_ready = DECERR_READY;
   assign DECERR_VALID = 1'b0;
   assign DECERR_ID    = '0;
   assign DECERR_LEN   = '0;
`endif

endmodule

// File: tb/tb_ar_router.sv
// Bench for ar_router: transaction-level reference model checked every cycle plus directed literal checks.
module tb_ar_router;
   localparam int NUM_M = 2, NUM_S = 2, ID_W = 4, ADDR_W = 32, SEL_LSB = 16;
   localparam int SID_W = ID_W + 4, SEL_W = 1;

   logic ACLK = 1'b0;
   logic ARESETn = 1'b0;
   logic [NUM_M*ID_W-1:0]   arid_m;
   logic [NUM_M*ADDR_W-1:0] araddr_m;
   logic [NUM_M*4-1:0]      arlen_m;
   logic [NUM_M*3-1:0]      arsize_m;
   logic [NUM_M*2-1:0]      arburst_m;
   logic [NUM_M-1:0]        ARVALID_M, ARREADY_M;
   logic [NUM_S*SID_W-1:0]  ARID_S;
   logic [NUM_S*ADDR_W-1:0] ARADDR_S;
   logic [NUM_S*4-1:0]      ARLEN_S;
   logic [NUM_S*3-1:0]      ARSIZE_S;
   logic [NUM_S*2-1:0]      ARBURST_S;
   logic [NUM_S-1:0]        ARVALID_S, ARREADY_S;
   logic                    DECERR_VALID, DECERR_READY;
   logic [SID_W-1:0]        DECERR_ID;
   logic [3:0]              DECERR_LEN;

   int checks = 0;
   int errors = 0;
   int rdy_cnt [NUM_M];
   int gnt_log [$];

   always #5 ACLK = ~ACLK;

   ar_router #(.NUM_M(NUM_M), .NUM_S(NUM_S), .ID_W(ID_W), .ADDR_W(ADDR_W), .SEL_LSB(SEL_LSB)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .ARID_M(arid_m), .ARADDR_M(araddr_m), .ARLEN_M(arlen_m), .ARSIZE_M(arsize_m), .ARBURST_M(arburst_m),
      .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
      .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S),
      .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
      .DECERR_VALID(DECERR_VALID), .DECERR_ID(DECERR_ID), .DECERR_LEN(DECERR_LEN), .DECERR_READY(DECERR_READY)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge ACLK);
      #2;
   endtask

   task automatic req(input int m, input logic [3:0] id, input logic [31:0] a, input logic [3:0] len);
      arid_m[m*4 +: 4]    = id;
      araddr_m[m*32 +: 32] = a;
      arlen_m[m*4 +: 4]   = len;
      arsize_m[m*3 +: 3]  = 3'(m + 2);
      arburst_m[m*2 +: 2] = 2'(m + 1);
      ARVALID_M[m]        = 1'b1;
   endtask

   always @(negedge ACLK) begin
      for (int m = 0; m < NUM_M; m++)
         if (ARVALID_M[m] && ARREADY_M[m]) begin
            rdy_cnt[m]++;
            gnt_log.push_back(m);
         end
   end

   // Reference model: 0 = no request held, 1 = routed to slave, 2 = decode error pending.
   int ms = 0, rr = 0, m_mst = 0, m_sel = 0;
   logic [3:0]  m_id, m_len;
   logic [31:0] m_addr;
   logic [2:0]  m_size;
   logic [1:0]  m_burst;

   always @(negedge ACLK) begin
      logic [NUM_M-1:0] e_rdy;
      logic [NUM_S-1:0] e_vs;
      logic [15:0] e_id;
      logic [63:0] e_addr;
      logic [7:0]  e_len;
      logic [5:0]  e_size;
      logic [3:0]  e_burst;
      logic        e_dv;
      logic [7:0]  e_did;
      logic [3:0]  e_dlen;
      int win, idx, cand;
      logic [31:0] upper;
      e_rdy = '0; e_vs = '0; e_id = '0; e_addr = '0; e_len = '0; e_size = '0; e_burst = '0;
      e_dv = 1'b0; e_did = '0; e_dlen = '0;
      if (!ARESETn) begin
         ms = 0;
         rr = 0;
      end else if (ms == 0) begin
         win = -1;
         for (int k = 0; k < NUM_M; k++) begin
            cand = (rr + k) % NUM_M;
            if (win < 0 && ARVALID_M[cand]) win = cand;
         end
         if (win >= 0) begin
            e_rdy[win] = 1'b1;
            m_mst   = win;
            m_id    = arid_m[win*4 +: 4];
            m_addr  = araddr_m[win*32 +: 32];
            m_len   = arlen_m[win*4 +: 4];
            m_size  = arsize_m[win*3 +: 3];
            m_burst = arburst_m[win*2 +: 2];
            idx     = int'((m_addr >> SEL_LSB) & ((32'd1 << SEL_W) - 1));
            upper   = m_addr >> (SEL_LSB + SEL_W);
            if (upper == 0 && idx < NUM_S) begin
               m_sel = idx;
               ms    = 1;
            end else begin
`ifdef AR_DECERR_EN
               ms = 2;
`else
               m_sel = NUM_S - 1;
               ms    = 1;
`endif
            end
         end
      end else if (ms == 1) begin
         e_vs[m_sel]          = 1'b1;
         e_id[m_sel*8 +: 8]   = {4'(m_mst), m_id};
         e_addr[m_sel*32 +: 32] = m_addr;
         e_len[m_sel*4 +: 4]  = m_len;
         e_size[m_sel*3 +: 3] = m_size;
         e_burst[m_sel*2 +: 2] = m_burst;
         if (ARREADY_S[m_sel]) begin
            ms = 0;
            rr = (m_mst + 1) % NUM_M;
         end
      end else begin
         e_dv   = 1'b1;
         e_did  = {4'(m_mst), m_id};
         e_dlen = m_len;
         if (DECERR_READY) begin
            ms = 0;
            rr = (m_mst + 1) % NUM_M;
         end
      end
      chk("m_arready_m", ARREADY_M, e_rdy);
      chk("m_arvalid_s", ARVALID_S, e_vs);
      chk("m_arid_s", ARID_S, e_id);
      chk("m_araddr_s", ARADDR_S, e_addr);
      chk("m_arlen_s", ARLEN_S, e_len);
      chk("m_arsize_s", ARSIZE_S, e_size);
      chk("m_arburst_s", ARBURST_S, e_burst);
      chk("m_decerr_v", DECERR_VALID, e_dv);
      chk("m_decerr_id", DECERR_ID, e_did);
      chk("m_decerr_len", DECERR_LEN, e_dlen);
   end

   initial begin
      int cnt1;
      logic [3:0] seq;
      arid_m = '0; araddr_m = '0; arlen_m = '0; arsize_m = '0; arburst_m = '0;
      ARVALID_M = 2'b11; ARREADY_S = 2'b11; DECERR_READY = 1'b0;

      // reset with both masters requesting
      repeat (2) @(negedge ACLK);
      chk("rst_arready_m", ARREADY_M, 2'b00);
      chk("rst_arvalid_s", ARVALID_S, 2'b00);
      chk("rst_decerr", DECERR_VALID, 1'b0);
      ARVALID_M = '0;
      @(posedge ACLK); #3 ARESETn = 1'b1;

      // single read, slave stalls 3 cycles
      step(); ARREADY_S = 2'b00; req(0, 4'h3, 32'h0000_0100, 4'h2);
      @(negedge ACLK);
      chk("t1_grant", ARREADY_M, 2'b01);
      chk("t1_no_vld_yet", ARVALID_S, 2'b00);
      step(); ARVALID_M[0] = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge ACLK);
         chk("t1_vld", ARVALID_S, 2'b01);
         chk("t1_id", ARID_S[7:0], 8'h03);
         chk("t1_addr", ARADDR_S[31:0], 32'h0000_0100);
         chk("t1_len", ARLEN_S[3:0], 4'h2);
         chk("t1_s1_zero", ARID_S[15:8], 8'h00);
         chk("t1_no_rdy_m", ARREADY_M, 2'b00);
      end
      step(); ARREADY_S = 2'b11;
      @(negedge ACLK); chk("t1_vld_last", ARVALID_S, 2'b01);
      @(negedge ACLK); chk("t1_idle", ARVALID_S, 2'b00);
      chk("t1_pulse_once", rdy_cnt[0], 1);

      // M1 to S1, ID prefixed by master index
      step(); req(1, 4'h5, 32'h0001_0040, 4'h0);
      @(negedge ACLK); chk("t2_grant", ARREADY_M, 2'b10);
      step(); ARVALID_M[1] = 1'b0;
      @(negedge ACLK);
      chk("t2_vld", ARVALID_S, 2'b10);
      chk("t2_id", ARID_S[15:8], 8'h15);
      chk("t2_addr", ARADDR_S[63:32], 32'h0001_0040);
      chk("t2_s0_zero", ARID_S[7:0], 8'h00);
      @(negedge ACLK); chk("t2_idle", ARVALID_S, 2'b00);

      // both masters continuously valid: alternate, one accept per 2 cycles
      step(); gnt_log.delete(); req(0, 4'h1, 32'h0000_0000, 4'h1); req(1, 4'h2, 32'h0001_0000, 4'h1);
      repeat (8) @(negedge ACLK);
      step(); ARVALID_M = '0;
      chk("t3_count", gnt_log.size(), 4);
      seq = 4'b1111;
      for (int i = 0; i < 4 && i < gnt_log.size(); i++) seq[3-i] = gnt_log[i][0];
      chk("t3_order", seq, 4'b0101);

      // M1 drops valid before being granted
      step(); ARREADY_S = 2'b00; req(0, 4'h9, 32'h0000_0000, 4'h0);
      @(negedge ACLK); chk("t4_grant", ARREADY_M, 2'b01);
      step(); ARVALID_M[0] = 1'b0; cnt1 = rdy_cnt[1]; req(1, 4'h4, 32'h0000_0000, 4'h0);
      repeat (2) @(negedge ACLK);
      step(); ARVALID_M[1] = 1'b0;
      @(negedge ACLK);
      step(); ARREADY_S = 2'b11;
      repeat (2) @(negedge ACLK);
      chk("t4_drop_ignored", rdy_cnt[1], cnt1);

      // decode miss
      step(); ARREADY_S = 2'b00; DECERR_READY = 1'b0; req(0, 4'h7, 32'h0004_0000, 4'h3);
      @(negedge ACLK); chk("t5_grant", ARREADY_M, 2'b01);
      step(); ARVALID_M[0] = 1'b0;
`ifdef AR_DECERR_EN
      for (int c = 0; c < 2; c++) begin
         @(negedge ACLK);
         chk("t5_decerr_v", DECERR_VALID, 1'b1);
         chk("t5_decerr_id", DECERR_ID, 8'h07);
         chk("t5_decerr_len", DECERR_LEN, 4'h3);
         chk("t5_no_slave", ARVALID_S, 2'b00);
      end
      step(); DECERR_READY = 1'b1;
      @(negedge ACLK);
      step(); DECERR_READY = 1'b0;
      @(negedge ACLK); chk("t5_decerr_done", DECERR_VALID, 1'b0);
      ARREADY_S = 2'b11;
`else
      @(negedge ACLK);
      chk("t5_to_s1", ARVALID_S, 2'b10);
      chk("t5_id", ARID_S[15:8], 8'h07);
      chk("t5_len", ARLEN_S[7:4], 4'h3);
      chk("t5_no_decerr", DECERR_VALID, 1'b0);
      step(); ARREADY_S = 2'b11;
      repeat (2) @(negedge ACLK);
      chk("t5_idle", ARVALID_S, 2'b00);
`endif

      // reset during SEND, then pointer back at M0
      step(); ARREADY_S = 2'b00; req(1, 4'hA, 32'h0000_0000, 4'h0);
      @(negedge ACLK); chk("t6_grant", ARREADY_M, 2'b10);
      step(); ARVALID_M[1] = 1'b0;
      @(negedge ACLK); chk("t6_send", ARVALID_S, 2'b01);
      @(posedge ACLK); #3 ARESETn = 1'b0; ARVALID_M = '0;
      #1 chk("t6_async_drop", ARVALID_S, 2'b00);
      @(posedge ACLK); #3 ARESETn = 1'b1; ARREADY_S = 2'b11;
      step(); req(0, 4'h1, 32'h0000_0000, 4'h0); req(1, 4'h2, 32'h0001_0000, 4'h0);
      @(negedge ACLK); chk("t6_first_m0", ARREADY_M, 2'b01);
      step(); ARVALID_M[0] = 1'b0;
      repeat (2) @(negedge ACLK); chk("t6_then_m1", ARREADY_M, 2'b10);
      step(); ARVALID_M[1] = 1'b0;
      repeat (3) @(negedge ACLK);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
